// File: rtl/shape_cmd_sequencer.sv
// Command sequencer: queues control words and plays each one to shape_processor
// as a write, a read-back and a held response, counting accepted/rejected writes.
module shape_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_data,
  output logic             write,
  output logic [31:0]      write_data,
  output logic             read,
  input  logic [31:0]      read_data,
  input  logic             error,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_error,
  output logic [CNT_W-1:0] accept_cnt,
  output logic [CNT_W-1:0] reject_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      PTR_ONE = (AW+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, WR, RD, RSP} state_e;

  state_e            state_q;
  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic              write_q, read_q, rsp_valid_q, rsp_error_q;
  logic [31:0]       write_data_q, rsp_data_q;
  logic [CNT_W-1:0]  accept_cnt_q, reject_cnt_q;
  logic              full, empty, push, pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign cmd_ready = rst_n && !full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = !empty && ((state_q == IDLE) || ((state_q == RSP) && rsp_ready));

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= cmd_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      read_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_error_q  <= 1'b0;
      write_data_q <= '0;
      rsp_data_q   <= '0;
      accept_cnt_q <= '0;
      reject_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q      <= WR;
            write_q      <= 1'b1;
            write_data_q <= mem_q[rd_ptr_q[AW-1:0]];
          end
        end
        WR: begin
          // The previous response is already consumed, so rsp_error may change here.
          state_q     <= RD;
          write_q     <= 1'b0;
          read_q      <= 1'b1;
          rsp_error_q <= error;
          if (error) begin
            if (reject_cnt_q != CNT_MAX) reject_cnt_q <= reject_cnt_q + CNT_ONE;
          end else begin
            if (accept_cnt_q != CNT_MAX) accept_cnt_q <= accept_cnt_q + CNT_ONE;
          end
        end
        RD: begin
          state_q     <= RSP;
          read_q      <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= read_data;
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (pop) begin
              state_q      <= WR;
              write_q      <= 1'b1;
              write_data_q <= mem_q[rd_ptr_q[AW-1:0]];
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign write      = write_q;
  assign read       = read_q;
  assign write_data = write_data_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_error  = rsp_error_q;
  assign accept_cnt = accept_cnt_q;
  assign reject_cnt = reject_cnt_q;
endmodule

// File: tb/tb_shape_cmd_sequencer.sv
// Directed bench for shape_cmd_sequencer with a tiny shape_processor model that
// rejects any word with bit 31 set and otherwise stores it as its control SFR.
module tb_shape_cmd_sequencer;
  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic        write;
  logic [31:0] write_data;
  logic        read;
  logic [31:0] read_data;
  logic        error;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic [1:0]  accept_cnt;
  logic [1:0]  reject_cnt;

  int          checks = 0;
  int          errors = 0;
  int          sent;
  int          nr;
  logic [31:0] got [8];
  logic [31:0] sfr = '0;
  logic        sawPulse;

  shape_cmd_sequencer #(.FIFO_DEPTH(4), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .write(write), .write_data(write_data), .read(read), .read_data(read_data),
    .error(error), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_error(rsp_error),
    .accept_cnt(accept_cnt), .reject_cnt(reject_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Processor model: error is judged in the write cycle, SFR only updates when accepted.
  assign error     = write & write_data[31];
  assign read_data = sfr;
  always @(posedge clk) if (write && !error) sfr <= write_data;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] data);
    cmd_valid = valid;
    cmd_data  = data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Streams commands base, base+1, ... and collects responses until total arrive or budget expires.
  task automatic runTraffic(input int total, input int startSent, input logic [31:0] base, input int budget);
    logic hs, rh;
    logic [31:0] rd;
    sent = startSent;
    nr   = 0;
    applyStimulus(sent < total, base + 32'(sent));
    for (int c = 0; c < budget && nr < total; c++) begin
      hs = cmd_valid && cmd_ready;
      rh = rsp_valid && rsp_ready;
      rd = rsp_data;
      tick();
      if (rh) begin
        got[nr] = rd;
        nr++;
      end
      if (hs) sent++;
      applyStimulus(sent < total, base + 32'(sent));
    end
    applyStimulus(1'b0, 32'h0);
  endtask

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 32'h0);
    repeat (3) tick();
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("rst_strobes", {29'd0, write, read, rsp_valid}, 32'd0);
    checkOutput("rst_write_data", write_data, 32'd0);
    checkOutput("rst_rsp", {rsp_data[30:0], rsp_error}, 32'd0);
    checkOutput("rst_counters", {28'd0, accept_cnt, reject_cnt}, 32'd0);
    rst_n = 1'b1;
    #1 checkOutput("release_cmd_ready", 32'(cmd_ready), 32'd1);

    // Single accepted command: push c0, write c2, read c3, response c4.
    rsp_ready = 1'b1;
    applyStimulus(1'b1, 32'h0000_0012);
    tick();
    applyStimulus(1'b0, 32'h0);
    checkOutput("c1_write", 32'(write), 32'd0);
    tick();
    checkOutput("c2_write", {30'd0, write, read}, 32'd2);
    checkOutput("c2_write_data", write_data, 32'h12);
    tick();
    checkOutput("c3_read", {30'd0, write, read}, 32'd1);
    checkOutput("c3_write_data_hold", write_data, 32'h12);
    checkOutput("c3_accept", 32'(accept_cnt), 32'd1);
    tick();
    checkOutput("c4_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("c4_rsp_data", rsp_data, 32'h12);
    checkOutput("c4_rsp_error", 32'(rsp_error), 32'd0);
    tick();
    checkOutput("c5_rsp_valid", 32'(rsp_valid), 32'd0);

    // Rejected command: SFR keeps 0x12, read still happens.
    applyStimulus(1'b1, 32'h8000_0034);
    tick();
    applyStimulus(1'b0, 32'h0);
    tick();
    checkOutput("rej_write", 32'(write), 32'd1);
    tick();
    checkOutput("rej_read", 32'(read), 32'd1);
    checkOutput("rej_counters", {28'd0, accept_cnt, reject_cnt}, 32'h5);
    tick();
    checkOutput("rej_rsp", {rsp_valid, rsp_error, rsp_data[29:0]}, {2'b11, 30'h12});
    tick();

    // Response stall: everything frozen for 10 cycles.
    rsp_ready = 1'b0;
    applyStimulus(1'b1, 32'h0000_0055);
    tick();
    applyStimulus(1'b0, 32'h0);
    repeat (3) tick();
    checkOutput("stall_start", {rsp_valid, rsp_error, rsp_data[29:0]}, {2'b10, 30'h55});
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("stall_flags", {28'd0, rsp_valid, rsp_error, write, read}, 32'h8);
      checkOutput("stall_data", rsp_data, 32'h55);
    end
    rsp_ready = 1'b1;
    tick();
    checkOutput("stall_release", 32'(rsp_valid), 32'd0);
    checkOutput("stall_accept", 32'(accept_cnt), 32'd2);

    // Backpressure: 6 commands with rsp_ready low, then drain.
    rsp_ready = 1'b0;
    runTraffic(6, 0, 32'h101, 8);
    checkOutput("bp_accepted", 32'(sent), 32'd5);
    checkOutput("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("bp_head_rsp", rsp_data, 32'h101);
    rsp_ready = 1'b1;
    runTraffic(6, 5, 32'h101, 60);
    checkOutput("bp_rsp_count", 32'(nr), 32'd6);
    checkOutput("bp_all_sent", 32'(sent), 32'd6);
    for (int i = 0; i < 6; i++) checkOutput("bp_order", got[i], 32'h101 + 32'(i));
    checkOutput("bp_counters", {28'd0, accept_cnt, reject_cnt}, 32'hD);

    // Reset during RD with two commands still queued.
    applyStimulus(1'b1, 32'h201);
    tick();
    applyStimulus(1'b1, 32'h202);
    tick();
    applyStimulus(1'b1, 32'h203);
    tick();
    applyStimulus(1'b0, 32'h0);
    checkOutput("mid_in_rd", 32'(read), 32'd1);
    rst_n = 1'b0;
    tick();
    checkOutput("mid_strobes", {29'd0, write, read, rsp_valid}, 32'd0);
    checkOutput("mid_counters", {28'd0, accept_cnt, reject_cnt}, 32'd0);
    checkOutput("mid_cmd_ready", 32'(cmd_ready), 32'd0);
    rst_n = 1'b1;
    #1 checkOutput("mid_release_ready", 32'(cmd_ready), 32'd1);
    sawPulse = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      sawPulse = sawPulse | write | read | rsp_valid;
    end
    checkOutput("mid_no_pulse", 32'(sawPulse), 32'd0);

    // Saturation: 5 accepted writes on a 2-bit counter.
    runTraffic(5, 0, 32'h301, 60);
    checkOutput("sat_rsp_count", 32'(nr), 32'd5);
    checkOutput("sat_last_rsp", got[4], 32'h305);
    checkOutput("sat_counters", {28'd0, accept_cnt, reject_cnt}, 32'hC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
